sha256_msg_sched: RTL and testbench

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

---
 rtl/sha256_msg_sched.sv | 94 +++++++++
 tb/tb_sha256_msg_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..63] through a
// 16-word sliding window, one word per valid/ready handshake.
module sha256_msg_sched (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic [31:0]  w_out,
  output logic [5:0]   w_index,
  output logic         w_valid,
  input  logic         w_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic        done_q, done_d;
  logic        hs;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    win_d   = win_q;
    done_d  = 1'b0;
    hs      = (state_q == RUN) && w_ready;
    // window[15] is about to become W[t+16]
    w_new   = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          t_d     = '0;
          for (int i = 0; i < 16; i++) begin
            win_d[i] = block_in[32*(15-i) +: 32];
          end
        end
      end
      RUN: begin
        if (hs) begin
          for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[15] = w_new;
          if (t_q == 6'd63) begin
            state_d = IDLE;
            t_d     = '0;
            done_d  = 1'b1;
          end else begin
            t_d = t_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  // t is cleared on leaving RUN, so w_index needs no gating
  assign w_valid = (state_q == RUN);
  assign busy    = (state_q == RUN);
  assign w_out   = (state_q == RUN) ? win_q[0] : 32'd0;
  assign w_index = t_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: hand-computed vector table plus
// multi-cycle sequences (stall, random ready, reset abort, ignored start).
module tb_sha256_msg_sched;

  logic         clock;
  logic         reset;
  logic         start;
  logic [511:0] block_in;
  logic [31:0]  w_out;
  logic [5:0]   w_index;
  logic         w_valid;
  logic         w_ready;
  logic         busy;
  logic         done;

  sha256_msg_sched dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .block_in(block_in),
    .w_out   (w_out),
    .w_index (w_index),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vecs = 0;
  int errs = 0;

  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];
  logic [5:0]  got_i [64];
  int          got_n;
  int          done_cnt;
  int          done_cyc;

  typedef struct {
    logic [511:0] blk;
    int           idx;
    logic [31:0]  exp;
  } vec_t;

  vec_t vt [9];

  localparam logic [511:0] ABC  = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] ZERO = 512'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule in the textbook array form.
  task automatic gold(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) exp_w[t] = blk[32*(15-t) +: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
      s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
      exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom();
    return b;
  endfunction

  // Called at a negedge; returns at the negedge after start was sampled.
  task automatic start_run(input logic [511:0] blk);
    block_in = blk;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check32("valid_after_start", 32'(w_valid), 32'd1);
    check32("index_after_start", 32'(w_index), 32'd0);
  endtask

  // mode 0: ready=1, mode 1: random ready, mode 2: stall 5 cycles at stall_at.
  // poke_at >= 0 re-pulses start with poke_blk when that index is presented.
  task automatic collect(input int mode, input int stall_at, input int poke_at,
                         input logic [511:0] poke_blk);
    int stall_left = 5;
    bit poked = 1'b0;
    int cyc = 0;
    int post = 0;
    got_n = 0; done_cnt = 0; done_cyc = -1;
    while (cyc < 2000 && post < 4) begin
      start = 1'b0;
      if (mode == 2 && w_valid && int'(w_index) == stall_at && stall_left > 0) begin
        w_ready = 1'b0;
        check32("stall_w_out", w_out, exp_w[stall_at]);
        check32("stall_w_index", 32'(w_index), 32'(stall_at));
        stall_left--;
      end else if (mode == 1) begin
        w_ready = 1'($urandom_range(0, 1));
      end else begin
        w_ready = 1'b1;
      end
      if (w_valid && int'(w_index) == poke_at && !poked) begin
        start    = 1'b1;
        block_in = poke_blk;
        poked    = 1'b1;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (w_valid && w_ready && got_n < 64) begin
        got_w[got_n] = w_out;
        got_i[got_n] = w_index;
        got_n++;
      end
      if (got_n == 64) post++;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    if (got_n < 64) begin
      vecs++; errs++;
      $display("FAIL collect_timeout: got %0d words, expected 64", got_n);
    end
  endtask

  task automatic check_stream(input string name);
    for (int t = 0; t < 64; t++) begin
      check32($sformatf("%s_w%0d", name, t), got_w[t], exp_w[t]);
      check32($sformatf("%s_idx%0d", name, t), 32'(got_i[t]), 32'(t));
    end
    check32($sformatf("%s_done_count", name), 32'(done_cnt), 32'd1);
    check32($sformatf("%s_idle_valid", name), 32'(w_valid), 32'd0);
    check32($sformatf("%s_idle_busy", name), 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] blk_a, blk_b;
    bit           found;

    vt[0] = '{ABC, 0, 32'h61626380};
    vt[1] = '{ABC, 1, 32'h00000000};
    vt[2] = '{ABC, 15, 32'h00000018};
    vt[3] = '{ABC, 16, 32'h61626380};
    vt[4] = '{ABC, 17, 32'h000F0000};
    vt[5] = '{ZERO, 0, 32'h00000000};
    vt[6] = '{ZERO, 31, 32'h00000000};
    vt[7] = '{ZERO, 63, 32'h00000000};
    vt[8] = '{{32'h11111111, 448'd0, 32'hdeadbeef}, 15, 32'hdeadbeef};

    reset = 1'b1; start = 1'b0; w_ready = 1'b0; block_in = '0;
    #12;
    check32("rst_w_valid", 32'(w_valid), 32'd0);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_done", 32'(done), 32'd0);
    check32("rst_w_out", w_out, 32'd0);
    check32("rst_w_index", 32'(w_index), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Table: first run starts on the first edge after reset release.
    for (int i = 0; i < 9; i++) begin
      start_run(vt[i].blk);
      collect(0, -1, -1, '0);
      check32($sformatf("vec%0d_W%0d", i, vt[i].idx), got_w[vt[i].idx], vt[i].exp);
    end

    gold(ABC);
    start_run(ABC);
    collect(0, -1, -1, '0);
    check_stream("abc");
    check32("abc_done_cycle", 32'(done_cyc), 32'd64);

    gold(ZERO);
    start_run(ZERO);
    collect(0, -1, -1, '0);
    check_stream("zero");
    check32("zero_done_cycle", 32'(done_cyc), 32'd64);

    blk_a = rand_block();
    gold(blk_a);
    start_run(blk_a);
    collect(2, 20, -1, '0);
    check_stream("stall");

    blk_a = rand_block();
    gold(blk_a);
    start_run(blk_a);
    collect(1, -1, -1, '0);
    check_stream("rand_ready");

    // Reset mid-run at W30
    blk_a = rand_block();
    gold(blk_a);
    start_run(blk_a);
    found = 1'b0;
    w_ready = 1'b1;
    for (int c = 0; c < 100 && !found; c++) begin
      if (w_valid && w_index == 6'd30) found = 1'b1;
      else @(negedge clock);
    end
    check32("reset_reach_30", 32'(found), 32'd1);
    #1 reset = 1'b1;
    #1;
    check32("abort_w_valid", 32'(w_valid), 32'd0);
    check32("abort_busy", 32'(busy), 32'd0);
    check32("abort_w_out", w_out, 32'd0);
    check32("abort_w_index", 32'(w_index), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check32("abort_no_valid", 32'(w_valid), 32'd0);
      check32("abort_no_done", 32'(done), 32'd0);
      @(negedge clock);
    end
    blk_b = rand_block();
    gold(blk_b);
    start_run(blk_b);
    check32("after_abort_W0", w_out, exp_w[0]);
    collect(0, -1, -1, '0);
    check_stream("after_abort");

    // start while busy is ignored, mid-run and on the final handshake
    blk_a = rand_block();
    blk_b = rand_block();
    gold(blk_a);
    start_run(blk_a);
    collect(0, -1, 10, blk_b);
    check_stream("restart10");

    start_run(blk_a);
    collect(0, -1, 63, blk_b);
    check_stream("restart63");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
